// File: rtl/perf_sample_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// perf_sample_ctrl_pkg
// Shared types for the performance-counter sampler: FSM state encoding,
// data word type and the sample record streamed to the trace sink.
// Revision: 1.0 - initial release
// ============================================================================
package perf_sample_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;

  // Sweep FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // One streamed sample: counter address plus its value
  typedef struct packed {
    logic [4:0] addr;
    xlen_t      data;
  } sample_t;

endpackage : perf_sample_ctrl_pkg
`default_nettype wire

// File: rtl/perf_sample_timer.sv
`default_nettype none
// ============================================================================
// perf_sample_timer
// Period timer for the sampler. Counts enabled, non-debug cycles and
// pulses tick_o when the count reaches period_i-1, then restarts from 0.
// Held at 0 while disabled or when period_i is 0; frozen in debug mode.
// Revision: 1.0 - initial release
// ============================================================================
module perf_sample_timer
  import perf_sample_ctrl_pkg::*;
#(
  parameter int PeriodWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   debug_mode_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic                   tick_o
);

  logic [PeriodWidth-1:0] timer_q;
  logic [PeriodWidth-1:0] timer_d;
  logic                   active;

  assign active = en_i && (period_i != '0) && !debug_mode_i;
  assign tick_o = active && (timer_q == (period_i - PeriodWidth'(1)));

  // Next timer value: clear when disabled or on tick, advance when active
  always_comb begin
    timer_d = timer_q;
    if (!en_i || (period_i == '0)) begin
      timer_d = '0;
    end else if (tick_o) begin
      timer_d = '0;
    end else if (active) begin
      timer_d = timer_q + PeriodWidth'(1);
    end
  end

  // Timer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule : perf_sample_timer
`default_nettype wire

// File: rtl/perf_sample_ctrl.sv
`default_nettype none
// ============================================================================
// perf_sample_ctrl
// Periodic sampler and access arbiter for the performance-counter port.
// The CSR file always owns the port when it requests it; otherwise a sweep
// engine reads a window of counters each period and streams {addr, value}
// samples over valid/ready.
// Optional macro PERF_SAMPLE_CLEAR_EN: sweep reads also zero the counter
// (write-after-read), so samples become deltas. An increment landing in the
// same cycle as the clearing read is lost.
// Revision: 1.0 - initial release
// ============================================================================
module perf_sample_ctrl
  import perf_sample_ctrl_pkg::*;
#(
  parameter logic [4:0] FirstAddr   = 5'd0,
  parameter int         NumCounters = 15,
  parameter int         PeriodWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   debug_mode_i,
  input  logic                   en_i,
  input  logic [PeriodWidth-1:0] period_i,
  input  logic                   csr_req_i,
  input  logic [4:0]             csr_addr_i,
  input  logic                   csr_we_i,
  input  xlen_t                  csr_wdata_i,
  output xlen_t                  csr_rdata_o,
  output logic [4:0]             pc_addr_o,
  output logic                   pc_we_o,
  output xlen_t                  pc_wdata_o,
  input  xlen_t                  pc_rdata_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [4:0]             sample_addr_o,
  output xlen_t                  sample_data_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int IdxW = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCounters - 1);

  state_t          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  sample_t         sample_q, sample_d;
  logic            overrun_q, overrun_d;
  logic            tick;
  logic [4:0]      sweep_addr;

  perf_sample_timer #(
    .PeriodWidth (PeriodWidth)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .debug_mode_i (debug_mode_i),
    .period_i     (period_i),
    .tick_o       (tick)
  );

  assign sweep_addr     = FirstAddr + 5'(idx_q);
  assign csr_rdata_o    = pc_rdata_i;
  assign sample_valid_o = (state_q == ST_SEND);
  assign sample_addr_o  = sample_q.addr;
  assign sample_data_o  = sample_q.data;
  assign busy_o         = (state_q != ST_IDLE);
  assign overrun_o      = overrun_q;

  // Port mux: CSR has absolute priority, sweep drives the port only in READ
  always_comb begin
    pc_addr_o  = '0;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (state_q == ST_READ) begin
      pc_addr_o = sweep_addr;
`ifdef PERF_SAMPLE_CLEAR_EN
      // Clear only on a read that will actually be captured (not an abort)
      pc_we_o   = en_i;
`else
      pc_we_o   = 1'b0;
`endif
    end
  end

  // Sweep FSM next state, index and sample capture
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (!csr_req_i) begin
          sample_d.addr = sweep_addr;
          sample_d.data = pc_rdata_i;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (sample_ready_i) begin
          if ((idx_q == LastIdx) || !en_i) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overrun: a tick arriving while a sweep is still active is dropped
  always_comb begin
    overrun_d = overrun_q;
    if (!en_i) begin
      overrun_d = 1'b0;
    end else if (tick && busy_o) begin
      overrun_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  end

endmodule : perf_sample_ctrl
`default_nettype wire

// File: tb/tb_perf_sample_ctrl.sv
`default_nettype none
// ============================================================================
// tb_perf_sample_ctrl
// Self-checking bench for perf_sample_ctrl: directed scenarios plus a
// randomized phase, with a scoreboard of expected sample addresses and a
// model of counter contents. Honors PERF_SAMPLE_CLEAR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_perf_sample_ctrl;
  import perf_sample_ctrl_pkg::*;

  localparam logic [4:0] FIRST = 5'd4;
  localparam int         NCNT  = 3;
  localparam int         PW    = 32;
`ifdef PERF_SAMPLE_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          debug_mode_i, en_i, csr_req_i, csr_we_i, sample_ready_i;
  logic [PW-1:0] period_i;
  logic [4:0]    csr_addr_i, pc_addr_o, sample_addr_o;
  xlen_t         csr_wdata_i, csr_rdata_o, pc_wdata_o, pc_rdata_i, sample_data_o;
  logic          pc_we_o, sample_valid_o, busy_o, overrun_o;

  // Counter block stand-in and the bench's own view of its contents
  xlen_t mem[32];
  xlen_t ref_mem[32];
  logic [4:0] exp_q[$];
  int unsigned act_cnt;
  int remaining;
  bit exp_ovr, m_act, m_tick, m_busy, m_hs;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, t1;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  perf_sample_ctrl #(
    .FirstAddr   (FIRST),
    .NumCounters (NCNT),
    .PeriodWidth (PW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .debug_mode_i   (debug_mode_i),
    .en_i           (en_i),
    .period_i       (period_i),
    .csr_req_i      (csr_req_i),
    .csr_addr_i     (csr_addr_i),
    .csr_we_i       (csr_we_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .pc_addr_o      (pc_addr_o),
    .pc_we_o        (pc_we_o),
    .pc_wdata_o     (pc_wdata_o),
    .pc_rdata_i     (pc_rdata_i),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .sample_addr_o  (sample_addr_o),
    .sample_data_o  (sample_data_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
  );

  assign pc_rdata_i = mem[pc_addr_o];
  always @(posedge clk_i) if (pc_we_o) mem[pc_addr_o] <= pc_wdata_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // kind 0: idle, 1: busy, 2: sample valid, 3: in a read cycle
  task automatic wait_for(input int kind, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      step();
      case (kind)
        0:       hit = !busy_o;
        1:       hit = busy_o;
        2:       hit = sample_valid_o;
        default: hit = busy_o && !sample_valid_o;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: condition not reached within 200 cycles", name);
    end
  endtask

  // Reference model: ticks from counted active cycles, sweeps as whole
  // sequences of addresses, overrun as "tick while a sweep is outstanding"
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      act_cnt   = 0;
      remaining = 0;
      exp_ovr   = 1'b0;
      exp_q.delete();
    end else begin
      chk("busy", busy_o, remaining > 0);
      chk("overrun", overrun_o, exp_ovr);
      m_act  = en_i && (period_i != 0) && !debug_mode_i;
      m_tick = 1'b0;
      if (m_act) m_tick = ((act_cnt % period_i) == (period_i - 1));
      m_busy = remaining > 0;
      m_hs   = sample_valid_o && sample_ready_i;
      if (!en_i || period_i == 0) act_cnt = 0;
      else if (m_act) act_cnt++;
      if (!en_i) exp_ovr = 1'b0;
      else if (m_tick && m_busy) exp_ovr = 1'b1;
      if (m_tick && !m_busy) begin
        for (int i = 0; i < NCNT; i++) exp_q.push_back(FIRST + 5'(i));
        remaining = NCNT;
      end else if (m_busy) begin
        if (!en_i) begin
          if (m_hs) begin
            remaining = 0;
            while (exp_q.size() > 1) void'(exp_q.pop_back());
          end else if (!sample_valid_o) begin
            remaining = 0;
            exp_q.delete();
          end
        end else if (m_hs) begin
          remaining--;
        end
      end
    end
  end

  // Monitor: samples against the scoreboard, port mux against the bench's inputs
  always @(negedge clk_i) begin
    #1;
    if (rst_ni) begin
      if (sample_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("sample_unexpected", 1'b1, 1'b0);
        end else begin
          chk("sample_addr", sample_addr_o, exp_q[0]);
          chk("sample_data", sample_data_o, ref_mem[exp_q[0]]);
          if (sample_ready_i) begin
            if (CLEAR) ref_mem[exp_q[0]] = '0;
            void'(exp_q.pop_front());
          end
        end
      end
      if (csr_req_i) begin
        chk("csr_pc_addr", pc_addr_o, csr_addr_i);
        chk("csr_pc_we", pc_we_o, csr_we_i);
        chk("csr_pc_wdata", pc_wdata_o, csr_wdata_i);
        if (!csr_we_i) chk("csr_rdata", csr_rdata_o, ref_mem[csr_addr_i]);
      end else if (busy_o && !sample_valid_o && en_i && exp_q.size() > 0) begin
        chk("sweep_addr", pc_addr_o, exp_q[0]);
        chk("sweep_we", pc_we_o, CLEAR);
        chk("sweep_wdata", pc_wdata_o, 0);
      end else if (!busy_o) begin
        chk("idle_port", {pc_addr_o, pc_we_o}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    debug_mode_i = 0; en_i = 0; period_i = 0; csr_req_i = 0; csr_we_i = 0;
    csr_addr_i = 0; csr_wdata_i = 0; sample_ready_i = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < NCNT; i++) mem[FIRST + i] = xlen_t'((i + 1) * 10);
`ifdef PERF_SAMPLE_CLEAR_EN
    mem[FIRST] = 7;
`endif
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

    // Reset values
    repeat (3) step();
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_pc_addr", pc_addr_o, 0);
    chk("rst_pc_we", pc_we_o, 0);
    chk("rst_pc_wdata", pc_wdata_o, 0);
    rst_ni = 1;

    // Sweep start interval with an always-ready sink
    period_i = 8; en_i = 1; sample_ready_i = 1;
    wait_for(1, "first_sweep"); t0 = cyc;
    wait_for(0, "first_done");
    wait_for(1, "second_sweep"); t1 = cyc;
    chk("sweep_interval", t1 - t0, 8);

    // Sink stall for 5 cycles in SEND
    wait_for(2, "stall_valid_wait");
    sample_ready_i = 0;
    repeat (5) step();
    chk("stall_valid_held", sample_valid_o, 1);
    sample_ready_i = 1;

    // CSR takes the port during a sweep READ
    wait_for(3, "read_wait");
    csr_req_i = 1; csr_we_i = 1; csr_addr_i = 5'd20; csr_wdata_i = 32'hABCD_1234;
    ref_mem[20] = 32'hABCD_1234;
    step();
    csr_we_i = 0;
    #1 chk("csr_stall_no_valid", sample_valid_o, 0);
    chk("csr_write_landed", csr_rdata_o, 32'hABCD_1234);
    step();
    csr_req_i = 0;

    // Overrun with short period and stalled sink; cleared by en_i=0
    en_i = 0; step();
    period_i = 2; en_i = 1; sample_ready_i = 0;
    repeat (10) step();
    chk("overrun_set", overrun_o, 1);
    sample_ready_i = 1;
    repeat (6) step();
    chk("overrun_sticky", overrun_o, 1);
    en_i = 0; step(); step();
    chk("overrun_cleared", overrun_o, 0);

    // Debug mode freezes the timer for 10 cycles
    period_i = 8; en_i = 1; sample_ready_i = 1;
    wait_for(1, "dbg_first"); t0 = cyc;
    wait_for(0, "dbg_done");
    debug_mode_i = 1;
    repeat (10) step();
    debug_mode_i = 0;
    wait_for(1, "dbg_second"); t1 = cyc;
    chk("debug_freeze_interval", t1 - t0, 18);

    // en_i dropped in READ aborts the sweep
    en_i = 0; step();
    chk("abort_read", busy_o, 0);

    // Window contents through CSR reads
    for (int i = 0; i < NCNT; i++) begin
      csr_req_i = 1; csr_we_i = 0; csr_addr_i = FIRST + 5'(i);
      #1 chk("csr_window", csr_rdata_o, CLEAR ? 32'd0 : xlen_t'((i + 1) * 10));
      step();
    end
    csr_req_i = 0;

    // en_i dropped in SEND: handshake completes, then idle
    period_i = 8; en_i = 1; sample_ready_i = 0;
    wait_for(2, "send_wait");
    en_i = 0; step();
    chk("send_hold", sample_valid_o, 1);
    sample_ready_i = 1; step();
    chk("send_exit", busy_o, 0);

    // Randomized phase
    for (int seg = 0; seg < 4; seg++) begin
      en_i = 0; csr_req_i = 0; step();
      period_i = $urandom_range(1, 12);
      en_i = 1;
      for (int k = 0; k < 150; k++) begin
        sample_ready_i = ($urandom_range(0, 3) != 0);
        debug_mode_i   = ($urandom_range(0, 19) == 0);
        en_i           = ($urandom_range(0, 49) != 0);
        if ($urandom_range(0, 5) == 0) begin
          csr_req_i  = 1;
          csr_addr_i = 5'(16 + $urandom_range(0, 15));
          csr_we_i   = $urandom_range(0, 1) == 1;
          csr_wdata_i = $urandom;
          if (csr_we_i) ref_mem[csr_addr_i] = csr_wdata_i;
        end else begin
          csr_req_i = 0;
        end
        step();
      end
    end
    debug_mode_i = 0; csr_req_i = 0; csr_we_i = 0;

    // Asynchronous reset in SEND
    en_i = 0; step();
    period_i = 4; en_i = 1; sample_ready_i = 0;
    wait_for(2, "arst_send_wait");
    #1 rst_ni = 0;
    #1 chk("arst_valid", sample_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    en_i = 0;
    step(); step();
    rst_ni = 1;
    repeat (3) step();
    chk("arst_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_perf_sample_ctrl
`default_nettype wire
